// File: rtl/sliced_alu_pkg.sv
// Shared definitions for sliced_alu: slice width, FSM states and the Op encodings.
// Optional signed-overflow output is enabled by defining SLICED_ALU_OVF_EN.
package sliced_alu_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Logic-mode (M=1) operations; 8-15 pass A
  localparam logic [3:0] LOP_NOTA = 4'd0;
  localparam logic [3:0] LOP_AND  = 4'd1;
  localparam logic [3:0] LOP_OR   = 4'd2;
  localparam logic [3:0] LOP_XOR  = 4'd3;
  localparam logic [3:0] LOP_NAND = 4'd4;
  localparam logic [3:0] LOP_NOR  = 4'd5;
  localparam logic [3:0] LOP_XNOR = 4'd6;
  localparam logic [3:0] LOP_PASB = 4'd7;

  // Arithmetic-mode (M=0) operations; 4-15 pass A with no carry
  localparam logic [3:0] AOP_ADD  = 4'd0;
  localparam logic [3:0] AOP_SUB  = 4'd1;
  localparam logic [3:0] AOP_INC  = 4'd2;
  localparam logic [3:0] AOP_DEC  = 4'd3;

  // Carry fed into the LSB slice: INC adds it as the +1, DEC relies on all-ones B.
  function automatic logic init_carry(input logic m, input logic [3:0] op, input logic cin);
    logic c;
    c = 1'b0;
    if (!m) begin
      case (op)
        AOP_ADD, AOP_SUB: c = cin;
        AOP_INC:          c = 1'b1;
        default:          c = 1'b0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_slice4.sv
// One 4-bit combinational ALU slice; cin is the true carry into this slice.
module alu_slice4
  import sliced_alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic               m,
  input  logic [3:0]         op,
  output logic [SLICE_W-1:0] y,
  output logic               cout,
  output logic               cout_into_msb
);

  logic [SLICE_W-1:0] b_eff;
  logic               arith;
  logic [SLICE_W:0]   sum;
  logic [SLICE_W-1:0] low;

  always_comb begin
    b_eff = '0;
    arith = 1'b0;
    if (!m) begin
      case (op)
        AOP_ADD: begin b_eff = b;  arith = 1'b1; end
        AOP_SUB: begin b_eff = ~b; arith = 1'b1; end
        AOP_INC: begin b_eff = '0; arith = 1'b1; end
        AOP_DEC: begin b_eff = '1; arith = 1'b1; end
        default: ;
      endcase
    end

    sum = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
    low = {1'b0, a[SLICE_W-2:0]} + {1'b0, b_eff[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};

    y             = a;
    cout          = 1'b0;
    cout_into_msb = 1'b0;
    if (m) begin
      case (op)
        LOP_NOTA: y = ~a;
        LOP_AND:  y = a & b;
        LOP_OR:   y = a | b;
        LOP_XOR:  y = a ^ b;
        LOP_NAND: y = ~(a & b);
        LOP_NOR:  y = ~(a | b);
        LOP_XNOR: y = ~(a ^ b);
        LOP_PASB: y = b;
        default:  y = a;
      endcase
    end else if (arith) begin
      y             = sum[SLICE_W-1:0];
      cout          = sum[SLICE_W];
      cout_into_msb = low[SLICE_W-1];
    end
  end

endmodule

// File: rtl/sliced_alu.sv
// Multi-cycle ALU processing one 4-bit slice per cycle, LSB first, with valid/ready handshakes.
// Define SLICED_ALU_OVF_EN to add the registered signed-overflow output OVF.
module sliced_alu
  import sliced_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             M,
  input  logic [3:0]       Op,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] AluOut,
  output logic             COUT,
  output logic             ZERO,
  output logic             SIGN,
  output logic             EQ,
  output logic             LTU
`ifdef SLICED_ALU_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned N     = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t             state, next_state;
  logic [IDX_W-1:0]   idx;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q, b_q, work_q, next_res;
  logic               m_q;
  logic [3:0]         op_q;
  logic               last;

  logic [SLICE_W-1:0] slice_y;
  logic               slice_cout, slice_c_msb;

  alu_slice4 u_slice (
    .a             (a_q[idx*SLICE_W +: SLICE_W]),
    .b             (b_q[idx*SLICE_W +: SLICE_W]),
    .cin           (carry_q),
    .m             (m_q),
    .op            (op_q),
    .y             (slice_y),
    .cout          (slice_cout),
    .cout_into_msb (slice_c_msb)
  );

`ifndef SLICED_ALU_OVF_EN
  logic unused_c_msb;
  assign unused_c_msb = slice_c_msb;
`endif

  assign last = (idx == IDX_W'(N - 1));

  always_comb begin
    next_res = work_q;
    next_res[idx*SLICE_W +: SLICE_W] = slice_y;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    case (state)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) next_state = ST_RUN;
      end
      ST_RUN:  if (last) next_state = ST_DONE;
      ST_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Slices accumulate in work_q; visible outputs only load on the final slice,
  // so an aborted operation never exposes a partial result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      op_q    <= '0;
      work_q  <= '0;
      AluOut  <= '0;
      COUT    <= 1'b0;
      ZERO    <= 1'b0;
      SIGN    <= 1'b0;
      EQ      <= 1'b0;
      LTU     <= 1'b0;
`ifdef SLICED_ALU_OVF_EN
      OVF     <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE && IN_VALID) begin
        a_q     <= A;
        b_q     <= B;
        m_q     <= M;
        op_q    <= Op;
        idx     <= '0;
        carry_q <= init_carry(M, Op, CIN);
        work_q  <= '0;
      end else if (state == ST_RUN) begin
        work_q  <= next_res;
        carry_q <= slice_cout;
        idx     <= last ? '0 : idx + 1'b1;
        if (last) begin
          AluOut <= next_res;
          COUT   <= slice_cout;
          ZERO   <= (next_res == '0);
          SIGN   <= next_res[WIDTH-1];
          EQ     <= (a_q == b_q);
          LTU    <= (a_q < b_q);
`ifdef SLICED_ALU_OVF_EN
          OVF    <= slice_cout ^ slice_c_msb;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sliced_alu.sv
// Directed self-checking bench for sliced_alu at WIDTH=16 with hand-computed vectors.
module tb_sliced_alu;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  logic         CLK = 1'b0;
  logic         RST, IN_VALID, IN_READY, CIN, M, OUT_VALID, OUT_READY;
  logic [W-1:0] A, B, AluOut;
  logic [3:0]   Op;
  logic         COUT, ZERO, SIGN, EQ, LTU;
`ifdef SLICED_ALU_OVF_EN
  logic         OVF;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] held_out;
  logic [4:0]   held_flags;

  sliced_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CIN(CIN), .M(M), .Op(Op),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .AluOut(AluOut),
    .COUT(COUT), .ZERO(ZERO), .SIGN(SIGN), .EQ(EQ), .LTU(LTU)
`ifdef SLICED_ALU_OVF_EN
    , .OVF(OVF)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a bundle for the accepting edge, then scramble inputs to prove latching.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic m, input logic [3:0] op);
    A = a; B = b; CIN = cin; M = m; Op = op; IN_VALID = 1'b1;
    chk("accept_ready", {31'd0, IN_READY}, 32'd1);
    tick();
    IN_VALID = 1'b0;
    A = ~a; B = ~b; CIN = ~cin; M = ~m; Op = op ^ 4'hF;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 1; k < int'(N); k++) begin
      chk({tag, "_busy_valid"}, {31'd0, OUT_VALID}, 32'd0);
      chk({tag, "_busy_ready"}, {31'd0, IN_READY}, 32'd0);
      tick();
    end
    chk({tag, "_busy_valid_last"}, {31'd0, OUT_VALID}, 32'd0);
    tick();
    chk({tag, "_latency_valid"}, {31'd0, OUT_VALID}, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] y, input logic cout,
                           input logic zero, input logic sign, input logic eq,
                           input logic ltu, input logic ovf);
    chk({tag, "_out"},  {16'd0, AluOut}, {16'd0, y});
    chk({tag, "_flags"}, {27'd0, COUT, ZERO, SIGN, EQ, LTU},
        {27'd0, cout, zero, sign, eq, ltu});
`ifdef SLICED_ALU_OVF_EN
    chk({tag, "_ovf"}, {31'd0, OVF}, {31'd0, ovf});
`else
    if (ovf === 1'bx) chk({tag, "_ovf_x"}, 32'd0, 32'd1);
`endif
  endtask

  task automatic handshake(input string tag);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk({tag, "_hs_valid"}, {31'd0, OUT_VALID}, 32'd0);
    chk({tag, "_hs_ready"}, {31'd0, IN_READY}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic m, input logic [3:0] op,
                        input logic [W-1:0] y, input logic cout, input logic zero,
                        input logic sign, input logic eq, input logic ltu, input logic ovf);
    start_op(a, b, cin, m, op);
    wait_done(tag);
    check_res(tag, y, cout, zero, sign, eq, ltu, ovf);
    handshake(tag);
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A = '0; B = '0; CIN = 1'b0; M = 1'b0; Op = '0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_ready", {31'd0, IN_READY}, 32'd1);
    chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    check_res("rst", 16'h0000, 0, 0, 0, 0, 0, 0);

    //          tag     A        B        CIN M  Op    AluOut   CO Z  S  EQ LTU OVF
    run_op("add",   16'h1234, 16'h0FFF, 0, 0, 4'd0, 16'h2233, 0, 0, 0, 0, 0, 0);
    run_op("sub",   16'h0000, 16'h0001, 1, 0, 4'd1, 16'hFFFF, 0, 0, 1, 0, 1, 0);
    run_op("xor",   16'hAAAA, 16'hAAAA, 0, 1, 4'd3, 16'h0000, 0, 1, 0, 1, 0, 0);
    run_op("ovf",   16'h7FFF, 16'h0001, 0, 0, 4'd0, 16'h8000, 0, 0, 1, 0, 0, 1);
    run_op("inc",   16'hFFFF, 16'h1234, 0, 0, 4'd2, 16'h0000, 1, 1, 0, 0, 0, 0);
    run_op("dec",   16'h0000, 16'h0000, 1, 0, 4'd3, 16'hFFFF, 0, 0, 1, 1, 0, 0);
    run_op("sub2",  16'h0005, 16'h0003, 1, 0, 4'd1, 16'h0002, 1, 0, 0, 0, 0, 0);
    run_op("nand",  16'hFF00, 16'h0F0F, 0, 1, 4'd4, 16'hF0FF, 0, 0, 1, 0, 0, 0);
    run_op("lpasa", 16'h1357, 16'h2468, 1, 1, 4'd9, 16'h1357, 0, 0, 0, 0, 1, 0);
    run_op("apasa", 16'h8001, 16'h8001, 1, 0, 4'd7, 16'h8001, 0, 0, 1, 1, 0, 0);
    run_op("pasb",  16'h0000, 16'h00F0, 0, 1, 4'd7, 16'h00F0, 0, 0, 0, 0, 1, 0);
    run_op("not",   16'h0F0F, 16'h0F0F, 0, 1, 4'd0, 16'hF0F0, 0, 0, 1, 1, 0, 0);

    // Backpressure: hold the result five cycles while a new bundle is offered.
    start_op(16'h0001, 16'h0001, 0, 0, 4'd0);
    wait_done("bp");
    check_res("bp", 16'h0002, 0, 0, 0, 1, 0, 0);
    held_out   = AluOut;
    held_flags = {COUT, ZERO, SIGN, EQ, LTU};
    A = 16'hFFFF; B = 16'hFFFF; M = 1'b1; Op = 4'd0; IN_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("bp_hold_ready", {31'd0, IN_READY}, 32'd0);
      chk("bp_hold_out", {16'd0, AluOut}, {16'd0, held_out});
      chk("bp_hold_flags", {27'd0, COUT, ZERO, SIGN, EQ, LTU}, {27'd0, held_flags});
    end
    IN_VALID = 1'b0;
    handshake("bp");
    tick();
    chk("bp_no_queue_ready", {31'd0, IN_READY}, 32'd1);
    chk("bp_no_queue_valid", {31'd0, OUT_VALID}, 32'd0);

    // Reset pulsed during the second RUN cycle aborts with no partial output.
    start_op(16'h1111, 16'h2222, 0, 0, 4'd0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_mid_ready", {31'd0, IN_READY}, 32'd1);
    check_res("rst_mid", 16'h0000, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < int'(N) + 1; c++) begin
      tick();
      chk("rst_mid_idle", {31'd0, OUT_VALID}, 32'd0);
    end
    run_op("post_rst", 16'h1111, 16'h2222, 0, 0, 4'd0, 16'h3333, 0, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sliced_alu.md
SLICED_ALU -- requirements
Module: sliced_alu

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be a multiple of 4 and >= 4.
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: IN_VALID  input  1  operand/op bundle valid.
REQ-005 Port: IN_READY  output  1  block can accept a bundle.
REQ-006 Port: A, B  input  WIDTH  operands.
REQ-007 Port: CIN  input  1  carry-in for arithmetic ops.
REQ-008 Port: M  input  1  mode; 1 = logic, 0 = arithmetic.
REQ-009 Port: Op  input  4  operation select.
REQ-010 Port: OUT_VALID  output  1  result and flags valid.
REQ-011 Port: OUT_READY  input  1  consumer accepts the result.
REQ-012 Port: AluOut  output  WIDTH  result.
REQ-013 Port: COUT, ZERO, SIGN, EQ, LTU  output  1 each  carry-out, result==0, result MSB, A==B, unsigned A<B.

Function
REQ-014 Logic ops (M=1): Op 0 ~A, 1 A&B, 2 A|B, 3 A^B, 4 ~(A&B), 5 ~(A|B), 6 ~(A^B), 7 B, 8-15 A; COUT=0.
REQ-015 Arithmetic ops (M=0): Op 0 A+B+CIN, 1 A+~B+CIN, 2 A+1, 3 A-1 (A+all-ones), 4-15 A with COUT=0; result truncated to WIDTH, COUT = carry out of bit WIDTH-1.
REQ-016 Computation SHALL run one 4-bit slice per cycle, LSB slice first; carry between slices held in a register.
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on IN_VALID&IN_READY; RUN->DONE after slice N-1 (N=WIDTH/4); DONE->IDLE on OUT_VALID&OUT_READY.
REQ-018 IN_READY SHALL be 1 only in IDLE; OUT_VALID SHALL be 1 only in DONE.
REQ-019 A, B, CIN, M, Op SHALL be latched at the accepting edge; later input changes SHALL not affect the operation.
REQ-020 OUT_VALID SHALL rise exactly N cycles after the accepting edge.
REQ-021 AluOut and all flags SHALL be registered and stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 EQ and LTU SHALL be derived from the latched operands, independent of M and Op.
REQ-023 ZERO and SIGN SHALL reflect the final AluOut.
REQ-024 IN_VALID while not IDLE SHALL be ignored; no bundle is queued.
REQ-025 Max throughput: one operation per N+2 cycles (accept, N slice cycles, handshake).

Reset
REQ-026 RST=1 at an edge SHALL force IDLE, slice index 0, carry register 0, AluOut 0, and every flag 0 and OUT_VALID 0; IN_READY SHALL be 1 from the following cycle.
REQ-027 RST during RUN or DONE SHALL abort the operation and discard its result with no partial output.

Configuration
REQ-028 Macro SLICED_ALU_OVF_EN: when defined, adds port OVF output 1 = signed overflow of arithmetic ops (carry into MSB XOR carry out), 0 for logic ops, reset 0; when undefined, the port and its logic SHALL be absent and all other behaviour unchanged.

Structure
REQ-029 Package sliced_alu_pkg SHALL hold SLICE_W=4, the FSM state typedef, and named constants for the Op encodings of both modes.
REQ-030 Sub-module alu_slice4 (combinational: 4-bit a, b, cin, M, Op -> 4-bit y, cout, cout_into_msb) SHALL implement one slice; sliced_alu owns all state.

Verification (WIDTH=16)
REQ-031 ADD: A=0x1234, B=0x0FFF, CIN=0, M=0, Op=0 -> AluOut=0x2233, COUT=0, ZERO=0, OUT_VALID exactly 4 cycles after accept.
REQ-032 SUB: A=0x0000, B=0x0001, CIN=1, Op=1 -> AluOut=0xFFFF, COUT=0, SIGN=1, LTU=1, EQ=0.
REQ-033 XOR: A=B=0xAAAA, M=1, Op=3 -> AluOut=0x0000, ZERO=1, EQ=1, COUT=0.
REQ-034 Backpressure: OUT_READY held 0 for 5 cycles in DONE -> outputs constant, IN_READY=0, new IN_VALID ignored; accept on cycle 6, then IDLE.
REQ-035 Reset mid-op: RST pulsed on second RUN cycle -> next cycle OUT_VALID=0, AluOut=0, IN_READY=1; a following op computes correctly.
REQ-036 With SLICED_ALU_OVF_EN: A=0x7FFF, B=0x0001, CIN=0, Op=0 -> AluOut=0x8000, OVF=1, COUT=0.
